// File: rtl/sevenseg_reader_if.sv
// Observed seven-segment display bus, frame hand-off handshake and sticky status flags.
// The reader takes the slave view; whoever drives the display and consumes frames takes master.
interface sevenseg_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] out_digits;
  logic [2*NUM_DIGITS-1:0] out_kind;
  logic                    overrun;
  logic                    sel_err;

  modport master (
    output seg_in, dig_sel, out_ready,
    input  out_valid, out_digits, out_kind, overrun, sel_err
  );

  modport slave (
    input  seg_in, dig_sel, out_ready,
    output out_valid, out_digits, out_kind, overrun, sel_err
  );
endinterface

// File: rtl/sevenseg_reader.sv
// Recovers nibbles from a multiplexed seven-segment display: debounces each digit dwell,
// inverse-maps the segment pattern, assembles one full scan into a frame and offers it on valid/ready.
module sevenseg_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  sevenseg_reader_if.slave bus
);
  localparam int               RUN_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ARM = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       KIND_DEC   = 2'b00;
  localparam logic [1:0]       KIND_ERR   = 2'b01;
  localparam logic [1:0]       KIND_BLANK = 2'b10;
  localparam logic [1:0]       KIND_BAD   = 2'b11;

  logic [6:0]              r_seg;
  logic [6:0]              r_seg_prev;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [NUM_DIGITS-1:0]   r_sel_prev;
  logic [RUN_W-1:0]        r_run;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [3:0]              r_slot_nib  [NUM_DIGITS];
  logic [1:0]              r_slot_kind [NUM_DIGITS];
  logic                    r_out_valid;
  logic [4*NUM_DIGITS-1:0] r_out_digits;
  logic [2*NUM_DIGITS-1:0] r_out_kind;
  logic                    r_overrun;
  logic                    r_sel_err;

  logic                    w_same;
  logic                    w_sel_onehot;
  logic                    w_sel_multi;
  logic                    w_capture;
  logic                    w_frame_done;
  logic                    w_out_free;
  logic [RUN_W-1:0]        w_run_next;
  logic [3:0]              w_dec_nib;
  logic [1:0]              w_dec_kind;
  logic [4*NUM_DIGITS-1:0] w_frame_digits;
  logic [2*NUM_DIGITS-1:0] w_frame_kind;

  assign w_same       = (r_seg == r_seg_prev) && (r_sel == r_sel_prev);
  assign w_sel_onehot = (r_sel != '0) && ((r_sel & (r_sel - NUM_DIGITS'(1))) == '0);
  assign w_sel_multi  = (r_sel != '0) && !w_sel_onehot;
  // The run saturates, so stepping from STABLE_CYCLES-1 happens exactly once per dwell.
  assign w_capture    = w_same && (r_run == RUN_ARM) && w_sel_onehot;
  assign w_frame_done = &r_seen;
  assign w_out_free   = !r_out_valid || bus.out_ready;

  always_comb begin
    w_run_next = RUN_W'(1);
    if (w_same) begin
      if (r_run == RUN_MAX) begin
        w_run_next = RUN_MAX;
      end else begin
        w_run_next = r_run + RUN_W'(1);
      end
    end
  end

  always_comb begin
    w_dec_nib  = 4'h0;
    w_dec_kind = KIND_BAD;
    case (r_seg)
      7'b1110111: begin w_dec_nib = 4'd0; w_dec_kind = KIND_DEC; end
      7'b0010010: begin w_dec_nib = 4'd1; w_dec_kind = KIND_DEC; end
      7'b1011101: begin w_dec_nib = 4'd2; w_dec_kind = KIND_DEC; end
      7'b1011011: begin w_dec_nib = 4'd3; w_dec_kind = KIND_DEC; end
      7'b0111010: begin w_dec_nib = 4'd4; w_dec_kind = KIND_DEC; end
      7'b1101011: begin w_dec_nib = 4'd5; w_dec_kind = KIND_DEC; end
      7'b1101111: begin w_dec_nib = 4'd6; w_dec_kind = KIND_DEC; end
      7'b1010010: begin w_dec_nib = 4'd7; w_dec_kind = KIND_DEC; end
      7'b1111111: begin w_dec_nib = 4'd8; w_dec_kind = KIND_DEC; end
      7'b1111011: begin w_dec_nib = 4'd9; w_dec_kind = KIND_DEC; end
      // The decoder shows every value 10..15 as the same 'E' glyph.
      7'b1101101: begin w_dec_nib = 4'hE; w_dec_kind = KIND_ERR; end
      7'b0000000: begin w_dec_nib = 4'h0; w_dec_kind = KIND_BLANK; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg      <= '0;
      r_seg_prev <= '0;
      r_sel      <= '0;
      r_sel_prev <= '0;
      r_run      <= '0;
    end else begin
      r_seg      <= bus.seg_in;
      r_sel      <= bus.dig_sel;
      r_seg_prev <= r_seg;
      r_sel_prev <= r_sel;
      r_run      <= w_run_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_slot_nib[i]  <= '0;
        r_slot_kind[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_sel[i]) begin
          r_slot_nib[i]  <= w_dec_nib;
          r_slot_kind[i] <= w_dec_kind;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
    assign w_frame_digits[4*gi +: 4] = r_slot_nib[gi];
    assign w_frame_kind[2*gi +: 2]   = r_slot_kind[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen       <= '0;
      r_out_valid  <= 1'b0;
      r_out_digits <= '0;
      r_out_kind   <= '0;
      r_overrun    <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      r_seen <= (w_frame_done ? '0 : r_seen) | (w_capture ? r_sel : '0);
      if (w_sel_multi) begin
        r_sel_err <= 1'b1;
      end
      // A frame completing while the consumer accepts the previous one loads without a bubble.
      if (w_frame_done && w_out_free) begin
        r_out_valid  <= 1'b1;
        r_out_digits <= w_frame_digits;
        r_out_kind   <= w_frame_kind;
      end else begin
        if (w_frame_done) begin
          r_overrun <= 1'b1;
        end
        if (r_out_valid && bus.out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_digits = r_out_digits;
  assign bus.out_kind   = r_out_kind;
  assign bus.overrun    = r_overrun;
  assign bus.sel_err    = r_sel_err;
endmodule

// File: tb/tb_sevenseg_reader.sv
// Drives display scans into sevenseg_reader; a run-length reference model predicts frames
// into a queue that a separate handshake monitor pops and compares.
module tb_sevenseg_reader;
  localparam int N = 4;
  localparam int S = 3;

  typedef struct packed {
    logic [4*N-1:0] digits;
    logic [2*N-1:0] kind;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_reader_if #(.NUM_DIGITS(N)) bus ();

  sevenseg_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_t     exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         ready_mode = 2;   // 0 random (bounded hold), 1 held low, 2 always high
  int         n_acc = 0;
  logic       exp_overrun = 1'b0;
  logic       exp_sel_err = 1'b0;
  logic [6:0] codes [10];
  logic [6:0] m_last_seg;
  logic [N-1:0] m_last_sel;
  int         m_run;
  logic [N-1:0] m_seen;
  logic [3:0] m_dig  [N];
  logic [1:0] m_kind [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] inv_map(input logic [6:0] p);
    if (p == 7'b1101101) return {4'hE, 2'b01};
    if (p == 7'b0000000) return {4'h0, 2'b10};
    for (int d = 0; d < 10; d++) begin
      if (codes[d] == p) return {4'(d), 2'b00};
    end
    return {4'h0, 2'b11};
  endfunction

  task automatic model_reset();
    m_last_seg = '0;
    m_last_sel = '0;
    m_run = 0;
    m_seen = '0;
    exp_q.delete();
    exp_overrun = 1'b0;
    exp_sel_err = 1'b0;
  endtask

  // One displayed cycle: a digit is accepted once the same value has been shown S cycles in a row.
  task automatic model_step(input logic [6:0] seg, input logic [N-1:0] sel);
    frame_t f;
    if (seg == m_last_seg && sel == m_last_sel) m_run++;
    else m_run = 1;
    m_last_seg = seg;
    m_last_sel = sel;
    if (sel != '0 && !$onehot(sel)) exp_sel_err = 1'b1;
    if (m_run == S && $onehot(sel)) begin
      for (int i = 0; i < N; i++) begin
        if (sel[i]) {m_dig[i], m_kind[i]} = inv_map(seg);
      end
      m_seen |= sel;
      if (&m_seen) begin
        for (int i = 0; i < N; i++) begin
          f.digits[4*i +: 4] = m_dig[i];
          f.kind[2*i +: 2]   = m_kind[i];
        end
        exp_q.push_back(f);
        m_seen = '0;
      end
    end
  endtask

  task automatic drive(input logic [6:0] seg, input logic [N-1:0] sel, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.seg_in  = seg;
      bus.dig_sel = sel;
      model_step(seg, sel);
    end
  endtask

  task automatic blanks(input int n);
    drive(7'b0, '0, n);
  endtask

  task automatic scan(input logic [27:0] pats, input int dwell);
    for (int d = 0; d < N; d++) begin
      drive(pats[7*d +: 7], N'(1 << d), dwell);
    end
  endtask

  function automatic logic [27:0] pack4(input logic [6:0] d0, input logic [6:0] d1,
                                        input logic [6:0] d2, input logic [6:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      blanks(1);
      t++;
    end
    chk("drain_pending_frames", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.seg_in  = '0;
    bus.dig_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"},  bus.out_valid, 0);
    chk({tag, "_out_digits"}, bus.out_digits, 0);
    chk({tag, "_out_kind"},   bus.out_kind, 0);
    chk({tag, "_overrun"},    bus.overrun, 0);
    chk({tag, "_sel_err"},    bus.sel_err, 0);
  endtask

  // Handshake monitor: owns out_ready, pops the scoreboard on every accepted frame.
  initial begin : monitor
    frame_t f;
    logic   held;
    int     held_cnt;
    logic [4*N-1:0] held_digits;
    logic [2*N-1:0] held_kind;
    logic   rdy;
    held = 1'b0;
    held_cnt = 0;
    held_digits = '0;
    held_kind = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        held_cnt = 0;
        bus.out_ready = 1'b0;
      end else begin
        if (held) begin
          chk("hold_out_valid",  bus.out_valid, 1);
          chk("hold_out_digits", bus.out_digits, held_digits);
          chk("hold_out_kind",   bus.out_kind, held_kind);
        end
        case (ready_mode)
          0:       rdy = (held_cnt >= 3) || ($urandom_range(0, 1) == 1);
          1:       rdy = 1'b0;
          default: rdy = 1'b1;
        endcase
        bus.out_ready = rdy;
        if (bus.out_valid && rdy) begin
          n_acc++;
          $display("TX frame=%0d digits=%h kind=%h", n_acc, bus.out_digits, bus.out_kind);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got digits=%h kind=%h expected no frame",
                     bus.out_digits, bus.out_kind);
          end else begin
            f = exp_q.pop_front();
            chk("frame_digits", bus.out_digits, f.digits);
            chk("frame_kind",   bus.out_kind, f.kind);
          end
          held = 1'b0;
          held_cnt = 0;
        end else if (bus.out_valid) begin
          held = 1'b1;
          held_cnt++;
          held_digits = bus.out_digits;
          held_kind = bus.out_kind;
        end else begin
          held = 1'b0;
          held_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n0;
    logic [6:0]   seg;
    logic [N-1:0] sel;
    int r;
    codes[0] = 7'b1110111; codes[1] = 7'b0010010; codes[2] = 7'b1011101;
    codes[3] = 7'b1011011; codes[4] = 7'b0111010; codes[5] = 7'b1101011;
    codes[6] = 7'b1101111; codes[7] = 7'b1010010; codes[8] = 7'b1111111;
    codes[9] = 7'b1111011;
    bus.seg_in  = '0;
    bus.dig_sel = '0;
    model_reset();

    do_reset();
    chk_reset_state("reset");

    // Basic scan 1,2,3,4 held until ready.
    ready_mode = 1;
    blanks(2);
    scan(pack4(codes[1], codes[2], codes[3], codes[4]), 5);
    blanks(6);
    chk("t1_out_valid",  bus.out_valid, 1);
    chk("t1_out_digits", bus.out_digits, 16'h4321);
    chk("t1_out_kind",   bus.out_kind, 0);
    blanks(4);
    ready_mode = 2;
    wait_drain(20);
    blanks(2);
    chk("t1_valid_after_accept", bus.out_valid, 0);

    // Two scans with ready low: first held, second dropped; then a no-bubble hand-over.
    ready_mode = 1;
    scan(pack4(codes[5], codes[6], codes[7], codes[8]), 4);
    blanks(6);
    scan(pack4(codes[9], codes[0], codes[1], codes[2]), 3);
    blanks(6);
    chk("t4_overrun", bus.overrun, 1);
    chk("t4_held_digits", bus.out_digits, 16'h8765);
    chk("t4_model_frames_pending", exp_q.size(), 2);
    void'(exp_q.pop_back());
    exp_overrun = 1'b1;
    drive(codes[3], 4'b0001, 3);
    drive(codes[4], 4'b0010, 3);
    drive(codes[5], 4'b0100, 3);
    drive(codes[6], 4'b1000, 3);
    blanks(1);
    @(posedge clk);
    #1;
    ready_mode = 2;
    blanks(1);
    @(posedge clk);
    #1;
    chk("t5_nobubble_valid",  bus.out_valid, 1);
    chk("t5_nobubble_digits", bus.out_digits, 16'h6543);
    wait_drain(20);
    blanks(2);
    chk("t4_valid_after_accept", bus.out_valid, 0);

    // Special patterns: E, blank, invalid, 9.
    ready_mode = 1;
    scan(pack4(7'b1101101, 7'b0000000, 7'b1000000, codes[9]), 4);
    blanks(6);
    chk("t3_out_digits", bus.out_digits, 16'h900E);
    chk("t3_out_kind",   bus.out_kind, 8'h39);
    ready_mode = 2;
    wait_drain(20);

    // Back-to-back scans, always ready.
    n0 = n_acc;
    for (int k = 0; k < 3; k++) begin
      scan(pack4(codes[$urandom_range(0, 9)], codes[$urandom_range(0, 9)],
                 codes[$urandom_range(0, 9)], codes[$urandom_range(0, 9)]), 3);
    end
    blanks(8);
    wait_drain(30);
    chk("t5_frames", n_acc - n0, 3);
    chk("t5_overrun_sticky", bus.overrun, exp_overrun);

    // Short dwell on digit 2 completes nothing; a proper rescan does.
    n0 = n_acc;
    drive(codes[7], 4'b0001, 3);
    drive(codes[8], 4'b0010, 3);
    drive(codes[1], 4'b0100, 2);
    drive(codes[2], 4'b1000, 3);
    blanks(8);
    chk("t2_short_dwell_frames", n_acc - n0, 0);
    chk("t2_short_dwell_valid", bus.out_valid, 0);
    scan(pack4(codes[3], codes[4], codes[5], codes[6]), 3);
    blanks(8);
    wait_drain(30);
    chk("t2_rescan_frames", n_acc - n0, 1);

    // Non-one-hot select, then reset in the middle of a scan.
    n0 = n_acc;
    drive(codes[8], 4'b0011, 4);
    blanks(4);
    chk("t6_sel_err", bus.sel_err, 1);
    chk("t6_multi_sel_frames", n_acc - n0, 0);
    drive(codes[1], 4'b0001, 4);
    drive(codes[2], 4'b0010, 2);
    do_reset();
    chk_reset_state("t6_mid_reset");
    blanks(2);
    scan(pack4(codes[0], codes[7], codes[2], codes[9]), 3);
    blanks(8);
    wait_drain(30);
    chk("t6_frames_after_reset", n_acc - n0, 1);

    // Randomised display traffic with a randomly stalling consumer.
    ready_mode = 0;
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       seg = codes[$urandom_range(0, 9)];
      else if (r == 7) seg = 7'b1101101;
      else if (r == 8) seg = 7'b0000000;
      else             seg = 7'($urandom);
      r = $urandom_range(0, 19);
      if (r < 16)      sel = N'(1 << $urandom_range(0, N - 1));
      else if (r < 18) sel = '0;
      else             sel = N'($urandom);
      drive(seg, sel, $urandom_range(1, 6));
    end
    blanks(10);
    wait_drain(100);
    chk("rand_overrun", bus.overrun, exp_overrun);
    chk("rand_sel_err", bus.sel_err, exp_sel_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
